// File: rtl/operand_addrgen_pkg.sv
// Shared types for the tensorcore operand address generator: datatype enum,
// per-channel and tile configuration structs, FSM state type and element-shift helper.
package operand_addrgen_pkg;

  localparam int AG_ADDR_W = 32;
  localparam int AG_NUM_CH = 2;
  localparam int AG_DIM_W  = 8;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } datatype_e;

  typedef struct packed {
    logic [AG_ADDR_W-1:0] base;
    logic [AG_ADDR_W-1:0] row_stride;
    logic [AG_ADDR_W-1:0] limit;
    logic                 col_major;
  } addrgen_ch_cfg_t;

  typedef struct packed {
    datatype_e                             datatype;
    logic [AG_DIM_W-1:0]                   rows;
    logic [AG_DIM_W-1:0]                   cols;
    addrgen_ch_cfg_t [AG_NUM_CH-1:0]       ch;
  } addrgen_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ag_state_e;

  // Elements packed per word = 2**shift.
  function automatic logic [1:0] elem_shift(input datatype_e dt);
    case (dt)
      FP32:    return 2'd0;
      FP16:    return 2'd1;
      INT8:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/operand_addrgen_ch_iter.sv
// One address channel: row/col counters and an incrementally updated row base.
// With ADDRGEN_BOUNDS_CHK_EN defined, o_oob flags the current address above the latched limit.
module addrgen_ch_iter
  import operand_addrgen_pkg::*;
#(
  parameter int ADDR_W = AG_ADDR_W,
  parameter int DIM_W  = AG_DIM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  addrgen_ch_cfg_t       i_ch_cfg,
  input  logic [DIM_W-1:0]      i_rows,
  input  logic [DIM_W-1:0]      i_cols,
  input  logic [1:0]            i_shift,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [2:0]            o_lane,
  output logic                  o_oob
);

  logic [DIM_W-1:0]  r_row, r_col;
  logic [ADDR_W-1:0] r_base, r_stride, r_row_base;
  logic              r_cm;
  logic              w_row_last, w_col_last, w_adv_row, w_adv_col;
  logic [2:0]        w_mask;

  assign w_row_last = (r_row == i_rows - DIM_W'(1));
  assign w_col_last = (r_col == i_cols - DIM_W'(1));
  // The inner index advances every beat; the outer one only when the inner wraps.
  assign w_adv_row  = r_cm ? 1'b1 : w_col_last;
  assign w_adv_col  = r_cm ? w_row_last : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_base     <= '0;
      r_stride   <= '0;
      r_row_base <= '0;
      r_cm       <= 1'b0;
    end else if (i_load) begin
      r_row      <= '0;
      r_col      <= '0;
      r_base     <= i_ch_cfg.base;
      r_stride   <= i_ch_cfg.row_stride;
      r_row_base <= i_ch_cfg.base;
      r_cm       <= i_ch_cfg.col_major;
    end else if (i_step) begin
      if (w_adv_col) r_col <= w_col_last ? '0 : r_col + DIM_W'(1);
      if (w_adv_row) begin
        if (w_row_last) begin
          r_row      <= '0;
          r_row_base <= r_base;
        end else begin
          r_row      <= r_row + DIM_W'(1);
          r_row_base <= r_row_base + r_stride;
        end
      end
    end
  end

  always_comb begin
    w_mask = 3'b111;
    case (i_shift)
      2'd0:    w_mask = 3'b000;
      2'd1:    w_mask = 3'b001;
      2'd2:    w_mask = 3'b011;
      default: w_mask = 3'b111;
    endcase
  end

  assign o_addr = r_row_base + ADDR_W'(r_col >> i_shift);
  assign o_lane = r_col[2:0] & w_mask;

`ifdef ADDRGEN_BOUNDS_CHK_EN
  logic [ADDR_W-1:0] r_limit;

  always_ff @(posedge clk) begin
    if (!rst)        r_limit <= '0;
    else if (i_load) r_limit <= i_ch_cfg.limit;
  end

  assign o_oob = (o_addr > r_limit);
`else
  logic w_unused_limit;
  assign w_unused_limit = ^i_ch_cfg.limit;
  assign o_oob = 1'b0;
`endif

endmodule

// File: rtl/operand_addrgen.sv
// Multi-channel operand address generator: IDLE->RUN->DONE FSM, shared beat counter and last.
// Optional sticky bounds error enabled by defining ADDRGEN_BOUNDS_CHK_EN.
module operand_addrgen
  import operand_addrgen_pkg::*;
#(
  parameter int ADDR_W = AG_ADDR_W,
  parameter int NUM_CH = AG_NUM_CH,
  parameter int DIM_W  = AG_DIM_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  addrgen_cfg_t             i_cfg,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_addr_vld,
  input  logic [NUM_CH-1:0]        i_addr_rdy,
  output logic [NUM_CH*ADDR_W-1:0] o_addr,
  output logic [NUM_CH*3-1:0]      o_lane,
  output logic                     o_last,
  output logic                     o_oob_err,
  output ag_state_e                o_state
);

  localparam int CW = 2 * DIM_W;

  ag_state_e        r_state, w_next;
  logic             r_vld;
  logic [DIM_W-1:0] r_rows, r_cols;
  datatype_e        r_dtype;
  logic [CW-1:0]    r_total, r_beat;
  logic             w_load, w_xfer, w_last, w_empty;
  logic [NUM_CH-1:0] w_oob;

  // Handshake: a beat moves when o_addr_vld && every i_addr_rdy bit is high; while
  // any channel stalls, o_addr/o_lane/o_last hold and o_addr_vld stays asserted.
  assign w_load  = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_xfer  = r_vld && (&i_addr_rdy);
  assign w_last  = r_vld && (r_beat == r_total - CW'(1));
  assign w_empty = (i_cfg.rows == '0) || (i_cfg.cols == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = w_empty ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_xfer && w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (i_abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_vld   <= 1'b0;
      r_rows  <= '0;
      r_cols  <= '0;
      r_dtype <= FP32;
      r_total <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      r_vld   <= (w_next == ST_RUN);
      if (w_load) begin
        r_rows  <= i_cfg.rows;
        r_cols  <= i_cfg.cols;
        r_dtype <= i_cfg.datatype;
        r_total <= CW'(i_cfg.rows) * CW'(i_cfg.cols);
        r_beat  <= '0;
      end else if (w_xfer) begin
        r_beat  <= r_beat + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    addrgen_ch_iter #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_step   (w_xfer),
      .i_ch_cfg (i_cfg.ch[i]),
      .i_rows   (r_rows),
      .i_cols   (r_cols),
      .i_shift  (elem_shift(r_dtype)),
      .o_addr   (o_addr[i*ADDR_W +: ADDR_W]),
      .o_lane   (o_lane[i*3 +: 3]),
      .o_oob    (w_oob[i])
    );
  end

`ifdef ADDRGEN_BOUNDS_CHK_EN
  logic r_oob;

  always_ff @(posedge clk) begin
    if (!rst)                     r_oob <= 1'b0;
    else if (w_load)              r_oob <= 1'b0;
    else if (w_xfer && (|w_oob))  r_oob <= 1'b1;
  end

  assign o_oob_err = r_oob;
`else
  logic w_unused_oob;
  assign w_unused_oob = |w_oob;
  assign o_oob_err = 1'b0;
`endif

  assign o_busy     = (r_state == ST_RUN);
  assign o_done     = (r_state == ST_DONE);
  assign o_addr_vld = r_vld;
  assign o_last     = w_last;
  assign o_state    = r_state;

endmodule
